// File: rtl/analyzer_capture_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | analyzer_capture_seq: arm/clear/trigger/capture sequencer and channel-major |
// | read-out of the 16x64 capture bank. Option: ANALYZER_TRIG_TIMEOUT_EN.      |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module analyzer_capture_seq #(
  parameter int NUM_CH         = 16,
  parameter int SEL_W          = 4,
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 64,
  parameter int RD_LAT         = 2,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              trig_in_i,
  input  logic [NUM_CH-1:0] mem_full_i,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic              mem_clear_o,
  output logic              mem_wr_en_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  output logic [SEL_W-1:0]  chip_sel_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [SEL_W-1:0]  out_ch_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    ARMED    = 3'd2,
    CAPTURE  = 3'd3,
    RD_ISSUE = 3'd4,
    RD_WAIT  = 3'd5,
    RD_OUT   = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);
  localparam logic [SEL_W-1:0]  CH_LAST   = SEL_W'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t              state_q;
  logic                trig_prev_q;
  logic [CLR_W-1:0]    clr_cnt_q;
  logic [LAT_W-1:0]    lat_cnt_q;
  logic [SEL_W-1:0]    ch_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                mem_clear_q;
  logic                mem_wr_en_q;
  logic                mem_rd_en_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [SEL_W-1:0]    out_ch_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                out_last_q;
  logic                out_valid_q;

  logic                trig_rise;
  logic                any_full;
  logic                word_last;
  logic                tmo_hit;
  logic [ADDR_W-1:0]   addr_d;
  logic [SEL_W-1:0]    ch_d;

  assign trig_rise = trig_in_i & ~trig_prev_q;
  assign any_full  = |mem_full_i;
  assign word_last = (ch_q == CH_LAST) && (addr_q == ADDR_LAST);
  assign addr_d    = addr_q + 1'b1;
  assign ch_d      = (addr_q == ADDR_LAST) ? ch_q + 1'b1 : ch_q;

`ifdef ANALYZER_TRIG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q == ARMED) && (tmo_cnt_q == TMO_LAST);

  // Held at zero outside ARMED so every entry into ARMED starts a fresh count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ARMED) begin
      tmo_cnt_q <= '0;
    end else if (tmo_cnt_q != TMO_LAST) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      trig_prev_q <= 1'b0;
      clr_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      ch_q        <= '0;
      addr_q      <= '0;
      mem_clear_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      trig_prev_q <= trig_in_i;
      if (abort_i) begin
        state_q     <= IDLE;
        clr_cnt_q   <= '0;
        lat_cnt_q   <= '0;
        ch_q        <= '0;
        addr_q      <= '0;
        mem_clear_q <= 1'b0;
        mem_wr_en_q <= 1'b0;
        mem_rd_en_q <= 1'b0;
        out_last_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (arm_i) begin
              state_q     <= CLEAR;
              mem_clear_q <= 1'b1;
              clr_cnt_q   <= '0;
              ch_q        <= '0;
              addr_q      <= '0;
            end
          end
          CLEAR: begin
            if (clr_cnt_q == CLR_LAST) begin
              state_q     <= ARMED;
              mem_clear_q <= 1'b0;
            end else begin
              clr_cnt_q <= clr_cnt_q + 1'b1;
            end
          end
          ARMED: begin
            if (trig_rise || tmo_hit) begin
              state_q     <= CAPTURE;
              mem_wr_en_q <= 1'b1;
            end
          end
          CAPTURE: begin
            if (any_full) begin
              state_q     <= RD_ISSUE;
              mem_wr_en_q <= 1'b0;
              mem_rd_en_q <= 1'b1;
            end
          end
          RD_ISSUE: begin
            state_q   <= RD_WAIT;
            lat_cnt_q <= '0;
          end
          RD_WAIT: begin
            if (lat_cnt_q == LAT_LAST) begin
              state_q     <= RD_OUT;
              out_data_q  <= mem_dout_i;
              out_ch_q    <= ch_q;
              out_addr_q  <= addr_q;
              out_last_q  <= word_last;
              out_valid_q <= 1'b1;
            end else begin
              lat_cnt_q <= lat_cnt_q + 1'b1;
            end
          end
          RD_OUT: begin
            if (out_valid_q && out_ready_i) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              if (word_last) begin
                state_q     <= DONE;
                mem_rd_en_q <= 1'b0;
                ch_q        <= '0;
                addr_q      <= '0;
              end else begin
                state_q <= RD_ISSUE;
                addr_q  <= addr_d;
                ch_q    <= ch_d;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mem_clear_o   = mem_clear_q;
  assign mem_wr_en_o   = mem_wr_en_q;
  assign mem_rd_en_o   = mem_rd_en_q;
  assign mem_rd_addr_o = addr_q;
  assign chip_sel_o    = ch_q;
  assign out_data_o    = out_data_q;
  assign out_ch_o      = out_ch_q;
  assign out_addr_o    = out_addr_q;
  assign out_last_o    = out_last_q;
  assign out_valid_o   = out_valid_q;
  assign busy_o        = (state_q != IDLE) && (state_q != DONE);
  assign done_o        = (state_q == DONE);
  assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_analyzer_capture_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_analyzer_capture_seq: directed scenarios with a bench-side bank model.  |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module tb_analyzer_capture_seq;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 64;
  localparam int TMO    = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm, abort, trig, out_ready;
  logic [NUM_CH-1:0] mem_full;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_clear, mem_wr_en, mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr, out_addr;
  logic [SEL_W-1:0]  chip_sel, out_ch;
  logic [DATA_W-1:0] out_data;
  logic              out_last, out_valid, busy, done;
  logic [2:0]        state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  analyzer_capture_seq #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RD_LAT(2), .CLR_CYCLES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .arm_i(arm), .abort_i(abort), .trig_in_i(trig),
    .mem_full_i(mem_full), .mem_dout_i(mem_dout),
    .mem_clear_o(mem_clear), .mem_wr_en_o(mem_wr_en), .mem_rd_en_o(mem_rd_en),
    .mem_rd_addr_o(mem_rd_addr), .chip_sel_o(chip_sel),
    .out_data_o(out_data), .out_ch_o(out_ch), .out_addr_o(out_addr),
    .out_last_o(out_last), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done), .state_o(state)
  );

  function automatic logic [DATA_W-1:0] word_of(input int ch, input int a);
    logic [31:0] idx;
    idx = 32'(ch * 64 + a);
    return {16'hC0DE, 8'(ch), 8'(a), ~idx};
  endfunction

  // Bank model: flag goes up on the last free slot, read path is two registers deep
  int                wr_cnt;
  logic [DATA_W-1:0] rd_stage;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt   <= 0;
      rd_stage <= '0;
      mem_dout <= '0;
    end else begin
      if (mem_clear) wr_cnt <= 0;
      else if (mem_wr_en && wr_cnt < 64) wr_cnt <= wr_cnt + 1;
      rd_stage <= word_of(int'(chip_sel), int'(mem_rd_addr));
      mem_dout <= rd_stage;
    end
  end
  assign mem_full = (wr_cnt >= 63) ? 16'h0020 : 16'h0000;

  task automatic arm_to_armed();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input int ready_pct, input int nwords, output int first_cyc, output int last_cyc);
    int idx, cyc, ech, ea;
    logic r;
    idx = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
    while (idx < nwords && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (out_valid === 1'b1) begin
        ech = idx / 64; ea = idx % 64;
        checks++;
        if (out_data !== word_of(ech, ea) || out_ch !== SEL_W'(ech) ||
            out_addr !== ADDR_W'(ea) || out_last !== (idx == 1023)) begin
          errors++;
          $display("FAIL word%0d: got ch=%0d addr=%0d last=%b data=%h, want ch=%0d addr=%0d last=%b data=%h",
                   idx, out_ch, out_addr, out_last, out_data, ech, ea, (idx == 1023), word_of(ech, ea));
        end
        if (first_cyc < 0) first_cyc = cyc;
        r = (int'($urandom_range(99)) < ready_pct);
        out_ready = r;
        if (r) begin
          last_cyc = cyc;
          idx++;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    @(posedge clk); #1 out_ready = 1'b0;
    checks++;
    if (idx != nwords) begin
      errors++;
      $display("FAIL drain_count: got %0d words, want %0d", idx, nwords);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({mem_clear, mem_wr_en, mem_rd_en, out_last, out_valid, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, want 0000000",
               {mem_clear, mem_wr_en, mem_rd_en, out_last, out_valid, busy, done});
    end
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, want 0", state); end
    checks++;
    if (chip_sel !== '0 || mem_rd_addr !== '0 || out_ch !== '0 || out_addr !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_bus: got sel=%0d raddr=%0d och=%0d oaddr=%0d data=%h, want all 0",
               chip_sel, mem_rd_addr, out_ch, out_addr, out_data);
    end
  endtask

  task automatic test_capture();
    int n, f, l;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    checks++;
    if (state !== 3'd1 || mem_clear !== 1'b1) begin
      errors++; $display("FAIL clear_enter: got state=%0d clr=%b, want 1 1", state, mem_clear);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || mem_clear !== 1'b1) begin
      errors++; $display("FAIL clear_hold: got state=%0d clr=%b, want 1 1", state, mem_clear);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd2 || mem_clear !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL armed_enter: got state=%0d clr=%b busy=%b, want 2 0 1", state, mem_clear, busy);
    end
    repeat (5) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || mem_wr_en !== 1'b1) begin
      errors++; $display("FAIL trig_fire: got state=%0d wr=%b, want 3 1", state, mem_wr_en);
    end
    n = 0;
    while (mem_wr_en === 1'b1 && n < 200) begin n++; @(negedge clk); end
    checks++;
    if (n != 64) begin errors++; $display("FAIL wr_len: got %0d cycles, want 64", n); end
    checks++;
    if (state !== 3'd4 || mem_rd_en !== 1'b1 || chip_sel !== '0 || mem_rd_addr !== '0) begin
      errors++;
      $display("FAIL rd_issue: got state=%0d rd=%b sel=%0d addr=%0d, want 4 1 0 0", state, mem_rd_en, chip_sel, mem_rd_addr);
    end
    drain(100, 1024, f, l);
    checks++;
    if (f != 3) begin errors++; $display("FAIL rd_latency: got %0d cycles, want 3", f); end
    checks++;
    if (l - f != 4092) begin errors++; $display("FAIL dump_rate: got %0d cycles, want 4092", l - f); end
    @(negedge clk);
    checks++;
    if (state !== 3'd7 || done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL done_state: got state=%0d done=%b busy=%b valid=%b rd=%b, want 7 1 0 0 0",
               state, done, busy, out_valid, mem_rd_en);
    end
  endtask

  task automatic test_backpressure();
    int n, f, l;
    trig = 1'b0;
    arm_to_armed();
    trig = 1'b1;
    @(negedge clk);
    n = 0;
    while (mem_wr_en === 1'b1 && n < 200) begin n++; @(negedge clk); end
    checks++;
    if (n != 64) begin errors++; $display("FAIL bp_wr_len: got %0d cycles, want 64", n); end
    drain(50, 1024, f, l);
    @(negedge clk);
    checks++;
    if (state !== 3'd7 || done !== 1'b1) begin
      errors++; $display("FAIL bp_done: got state=%0d done=%b, want 7 1", state, done);
    end
  endtask

  task automatic test_trig_high();
    int bad;
    trig = 1'b1;
    arm_to_armed();
    bad = 0;
    repeat (100) begin
      if (state !== 3'd2 || mem_wr_en !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL trig_level: got %0d bad cycles, want 0", bad); end
    trig = 1'b0;
    @(negedge clk); trig = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd3 || mem_wr_en !== 1'b1) begin
      errors++; $display("FAIL trig_new_edge: got state=%0d wr=%b, want 3 1", state, mem_wr_en);
    end
    abort = 1'b1; arm = 1'b1;
    @(negedge clk); abort = 1'b0; arm = 1'b0;
    checks++;
    if (state !== 3'd0 || mem_wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_capture: got state=%0d wr=%b busy=%b, want 0 0 0", state, mem_wr_en, busy);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || mem_clear !== 1'b0) begin
      errors++; $display("FAIL abort_arm_ignored: got state=%0d clr=%b, want 0 0", state, mem_clear);
    end
    trig = 1'b0;
  endtask

  task automatic test_abort_rdout();
    int n, f, l;
    arm_to_armed();
    trig = 1'b1;
    @(negedge clk);
    n = 0;
    while (mem_wr_en === 1'b1 && n < 200) begin n++; @(negedge clk); end
    drain(100, 70, f, l);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 4'd1 || out_addr !== 6'd6) begin
      errors++; $display("FAIL stall_word: got valid=%b ch=%0d addr=%0d, want 1 1 6", out_valid, out_ch, out_addr);
    end
    abort = 1'b1; arm = 1'b1;
    @(negedge clk); abort = 1'b0; arm = 1'b0;
    checks++;
    if (state !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_rdout: got state=%0d valid=%b busy=%b rd=%b, want 0 0 0 0", state, out_valid, busy, mem_rd_en);
    end
    checks++;
    if (chip_sel !== '0 || mem_rd_addr !== '0) begin
      errors++; $display("FAIL abort_counters: got sel=%0d addr=%0d, want 0 0", chip_sel, mem_rd_addr);
    end
    trig = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    trig = 1'b0;
    arm_to_armed();
`ifdef ANALYZER_TRIG_TIMEOUT_EN
    n = 0;
    while (state === 3'd2 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n != TMO || state !== 3'd3 || mem_wr_en !== 1'b1) begin
      errors++; $display("FAIL timeout_fire: got %0d cycles state=%0d wr=%b, want %0d 3 1", n, state, mem_wr_en, TMO);
    end
`else
    n = 0;
    repeat (1000) begin
      if (state !== 3'd2 || mem_wr_en !== 1'b0) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 0 || state !== 3'd2) begin
      errors++; $display("FAIL no_timeout: got %0d bad cycles state=%0d, want 0 2", n, state);
    end
`endif
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || mem_clear !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: got state=%0d clr=%b busy=%b, want 0 0 0", state, mem_clear, busy);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_capture();
    test_backpressure();
    test_trig_high();
    test_abort_rdout();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
